// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: op-code encoding and its width.
package pc_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT    = 3'd0,
    OP_SKIP    = 3'd1,
    OP_GOTO    = 3'd2,
    OP_CALL    = 3'd3,
    OP_RETURN  = 3'd4,
    OP_RESTART = 3'd5,
    OP_RSVD6   = 3'd6,
    OP_RSVD7   = 3'd7
  } pc_op_e;

endpackage : pc_seq_pkg

// File: rtl/pc_sequencer_if.sv
// Decoder-side bus of the PC sequencer: op request in, pc/stack status out.
interface pc_sequencer_if #(
  parameter int unsigned PC_W        = 13,
  parameter int unsigned STACK_DEPTH = 8
);
  import pc_seq_pkg::*;

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               en;
  pc_op_e             op;
  logic [PC_W-1:0]    target;
  logic               clr_err;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    tos;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               ovf_err;
  logic               unf_err;

  modport master (
    output en, op, target, clr_err,
    input  pc, tos, depth, stack_full, stack_empty, ovf_err, unf_err
  );

  modport slave (
    input  en, op, target, clr_err,
    output pc, tos, depth, stack_full, stack_empty, ovf_err, unf_err
  );

endinterface : pc_sequencer_if

// File: rtl/pc_stack_lifo.sv
// Return-address LIFO for the PC sequencer.
// PC_SEQUENCER_STACK_WRAP_EN: push while full overwrites the oldest entry instead of being dropped.
module pc_stack_lifo #(
  parameter int unsigned PC_W        = 13,
  parameter int unsigned STACK_DEPTH = 8,
  localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1),
  localparam int unsigned PTR_W      = $clog2(STACK_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               clear_i,
  input  logic [PC_W-1:0]    wdata_i,
  output logic [PC_W-1:0]    tos_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [PC_W-1:0]    mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0]   top_idx;
  logic [PTR_W-1:0]   wptr_inc;
  logic               wr_en;

  // wptr is the next slot to write; it wraps modulo STACK_DEPTH so the ring also works for non-power-of-two depths
  assign top_idx  = (wptr_q == '0) ? PTR_W'(STACK_DEPTH - 1) : wptr_q - PTR_W'(1);
  assign wptr_inc = (wptr_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);

  assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign tos_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    wptr_d  = wptr_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    if (clear_i) begin
      wptr_d  = '0;
      depth_d = '0;
    end else if (push_i) begin
`ifdef PC_SEQUENCER_STACK_WRAP_EN
      wr_en  = 1'b1;
      wptr_d = wptr_inc;
      if (!full_o) depth_d = depth_q + DEPTH_W'(1);
`else
      if (!full_o) begin
        wr_en   = 1'b1;
        wptr_d  = wptr_inc;
        depth_d = depth_q + DEPTH_W'(1);
      end
`endif
    end else if (pop_i && !empty_o) begin
      wptr_d  = top_idx;
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      depth_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      depth_q <= depth_d;
    end
  end

  // Storage is deliberately not reset; only the pointer and depth are
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule : pc_stack_lifo

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return stack, skip, jump and soft restart.
// PC_SEQUENCER_STACK_WRAP_EN selects a circular (overwrite-oldest) return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W         = 13,
  parameter int unsigned     STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input logic            clk,
  input logic            reset_n,
  pc_sequencer_if.slave  bus
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               push, pop, clear;
  logic               ovf_set, unf_set;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    stk_tos;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full, stk_empty;

  pc_stack_lifo #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .wdata_i (pc_inc),
    .tos_o   (stk_tos),
    .depth_o (stk_depth),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // Next-pc mux and stack control
  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.en) begin
      case (bus.op)
        OP_SKIP: pc_d = pc_q + PC_W'(2);
        OP_GOTO: pc_d = bus.target;
        OP_CALL: begin
          push    = 1'b1;
          ovf_set = stk_full;
          pc_d    = bus.target;
        end
        OP_RETURN: begin
          if (stk_empty) begin
            unf_set = 1'b1;
            pc_d    = pc_inc;
          end else begin
            pop  = 1'b1;
            pc_d = stk_tos;
          end
        end
        OP_RESTART: begin
          clear = 1'b1;
          pc_d  = RESET_VECTOR;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  // A new error event outranks a simultaneous clear
  assign ovf_d = (ovf_q & ~bus.clr_err) | ovf_set;
  assign unf_d = (unf_q & ~bus.clr_err) | unf_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.tos         = stk_tos;
  assign bus.depth       = stk_depth;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a reference model feeding an expected-result queue.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int unsigned PC_W    = 13;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] RV  = '0;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    tos;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;
    logic               ovf;
    logic               unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  exp_t            exp_q [$];
  logic [PC_W-1:0] m_stk [$];
  logic [PC_W-1:0] m_pc;
  logic            m_ovf, m_unf;
  logic [PC_W-1:0] pushed [1:9];
  logic [PC_W-1:0] ret_exp;

  pc_sequencer_if #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc  = RV;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.tos   = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size() - 1];
    e.depth = DEPTH_W'(m_stk.size());
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_step(input logic e, input pc_op_e o, input logic [PC_W-1:0] t, input logic c);
    logic ovf_ev, unf_ev;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (e) begin
      case (o)
        OP_SKIP: m_pc = m_pc + PC_W'(2);
        OP_GOTO: m_pc = t;
        OP_CALL: begin
          if (m_stk.size() == DEPTH) begin
            ovf_ev = 1'b1;
`ifdef PC_SEQUENCER_STACK_WRAP_EN
            void'(m_stk.pop_front());
            m_stk.push_back(m_pc + PC_W'(1));
`endif
          end else begin
            m_stk.push_back(m_pc + PC_W'(1));
          end
          m_pc = t;
        end
        OP_RETURN: begin
          if (m_stk.size() == 0) begin
            unf_ev = 1'b1;
            m_pc   = m_pc + PC_W'(1);
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        OP_RESTART: begin
          m_pc = RV;
          m_stk.delete();
        end
        default: m_pc = m_pc + PC_W'(1);
      endcase
    end
    m_ovf = (m_ovf & ~c) | ovf_ev;
    m_unf = (m_unf & ~c) | unf_ev;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, ":queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ":pc"},    32'(bus.pc),          32'(e.pc));
    chk({tag, ":tos"},   32'(bus.tos),         32'(e.tos));
    chk({tag, ":depth"}, 32'(bus.depth),       32'(e.depth));
    chk({tag, ":full"},  32'(bus.stack_full),  32'(e.full));
    chk({tag, ":empty"}, 32'(bus.stack_empty), 32'(e.empty));
    chk({tag, ":ovf"},   32'(bus.ovf_err),     32'(e.ovf));
    chk({tag, ":unf"},   32'(bus.unf_err),     32'(e.unf));
  endtask

  // Drive one op at negedge, queue the model's expectation, compare #1 after the edge
  task automatic step(input string tag, input logic e, input pc_op_e o,
                      input logic [PC_W-1:0] t, input logic c);
    @(negedge clk);
    bus.en      = e;
    bus.op      = o;
    bus.target  = t;
    bus.clr_err = c;
    model_step(e, o, t, c);
    exp_q.push_back(model_snapshot());
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ":pc"},    32'(bus.pc),          32'(RV));
    chk({tag, ":depth"}, 32'(bus.depth),       32'd0);
    chk({tag, ":tos"},   32'(bus.tos),         32'd0);
    chk({tag, ":empty"}, 32'(bus.stack_empty), 32'd1);
    chk({tag, ":full"},  32'(bus.stack_full),  32'd0);
    chk({tag, ":ovf"},   32'(bus.ovf_err),     32'd0);
    chk({tag, ":unf"},   32'(bus.unf_err),     32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.en      = 1'b0;
    bus.op      = OP_NEXT;
    bus.target  = '0;
    bus.clr_err = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) step("next", 1'b1, OP_NEXT, '0, 1'b0);
    chk("next5_pc", 32'(bus.pc), 32'd5);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, OP_CALL, 13'h0AA, 1'b0);
    chk("hold_pc", 32'(bus.pc), 32'd5);

    step("goto_1ffe", 1'b1, OP_GOTO, 13'h1FFE, 1'b0);
    step("skip_wrap", 1'b1, OP_SKIP, '0, 1'b0);
    chk("skip_wrap_pc", 32'(bus.pc), 32'h0000);
    step("next_wrap", 1'b1, OP_NEXT, '0, 1'b0);
    chk("next_after_wrap_pc", 32'(bus.pc), 32'h0001);
    step("goto_1fff", 1'b1, OP_GOTO, 13'h1FFF, 1'b0);
    step("rsvd7", 1'b1, OP_RSVD7, '0, 1'b0);
    chk("rsvd_wrap_pc", 32'(bus.pc), 32'h0000);

    step("goto_20", 1'b1, OP_GOTO, 13'h020, 1'b0);
    step("call_100", 1'b1, OP_CALL, 13'h100, 1'b0);
    step("call_200", 1'b1, OP_CALL, 13'h200, 1'b0);
    chk("nest_depth", 32'(bus.depth), 32'd2);
    chk("nest_tos", 32'(bus.tos), 32'h101);
    step("ret_1", 1'b1, OP_RETURN, '0, 1'b0);
    chk("ret1_pc", 32'(bus.pc), 32'h101);
    step("ret_2", 1'b1, OP_RETURN, '0, 1'b0);
    chk("ret2_pc", 32'(bus.pc), 32'h021);
    chk("ret2_empty", 32'(bus.stack_empty), 32'd1);

    // Nine calls into an eight-deep stack
    for (int k = 1; k <= 9; k++) begin
      pushed[k] = bus.pc + PC_W'(1);
      step("ovf_call", 1'b1, OP_CALL, PC_W'(13'h300 + 13'(k * 16)), 1'b0);
    end
    chk("ovf_flag", 32'(bus.ovf_err), 32'd1);
    chk("ovf_depth", 32'(bus.depth), 32'd8);
    for (int j = 0; j < 8; j++) begin
`ifdef PC_SEQUENCER_STACK_WRAP_EN
      ret_exp = pushed[9 - j];
`else
      ret_exp = pushed[8 - j];
`endif
      step("ovf_ret", 1'b1, OP_RETURN, '0, 1'b0);
      chk("ovf_ret_pc", 32'(bus.pc), 32'(ret_exp));
    end
    step("clr_ovf", 1'b1, OP_NEXT, '0, 1'b1);
    chk("ovf_cleared", 32'(bus.ovf_err), 32'd0);

    step("goto_40", 1'b1, OP_GOTO, 13'h040, 1'b0);
    step("unf_ret", 1'b1, OP_RETURN, '0, 1'b0);
    chk("unf_pc", 32'(bus.pc), 32'h041);
    chk("unf_flag", 32'(bus.unf_err), 32'd1);
    step("unf_ret_clr", 1'b1, OP_RETURN, '0, 1'b1);
    chk("unf_wins_clr", 32'(bus.unf_err), 32'd1);
    chk("unf_depth0", 32'(bus.depth), 32'd0);
    step("clr_alone", 1'b0, OP_NEXT, '0, 1'b1);
    chk("unf_cleared", 32'(bus.unf_err), 32'd0);

    step("c1", 1'b1, OP_CALL, 13'h111, 1'b0);
    step("c2", 1'b1, OP_CALL, 13'h222, 1'b0);
    step("c3", 1'b1, OP_CALL, 13'h333, 1'b0);
    step("restart", 1'b1, OP_RESTART, '0, 1'b0);
    chk("restart_pc", 32'(bus.pc), 32'(RV));
    chk("restart_depth", 32'(bus.depth), 32'd0);

    // Build some state, then pulse reset inside a CALL cycle
    step("pre_c1", 1'b1, OP_CALL, 13'h0C0, 1'b0);
    step("pre_ret_empty", 1'b1, OP_RETURN, '0, 1'b0);
    step("pre_ret", 1'b1, OP_RETURN, '0, 1'b0);
    @(negedge clk);
    bus.en     = 1'b1;
    bus.op     = OP_CALL;
    bus.target = 13'h555;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    #1;
    bus.en  = 1'b0;
    reset_n = 1'b1;

    step("post_call", 1'b1, OP_CALL, 13'h0AB, 1'b0);
    step("post_ret", 1'b1, OP_RETURN, '0, 1'b0);
    chk("post_ret_pc", 32'(bus.pc), 32'(RV + PC_W'(1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pc_sequencer
